// File: rtl/sliding_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sliding_window_pkg
// Description : Shared FSM state encoding and sum-width helper for the
//               sliding-window sample buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package sliding_window_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // A window of DEPTH words of WORD_WIDTH bits can never exceed this width.
    function automatic int sum_width(input int word_width, input int depth);
        return word_width + $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_channel_lane.sv
`default_nettype none
// ============================================================================
// Module      : sw_channel_lane
// Description : One channel's DEPTH-deep sample shift chain, with an optional
//               running window sum (SLIDING_WINDOW_SUM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module sw_channel_lane
    import sliding_window_pkg::*;
#(
    parameter int WORD_WIDTH = 4,
    parameter int DEPTH      = 21
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        shift,
    input  logic [WORD_WIDTH-1:0]       din,
    output logic [DEPTH*WORD_WIDTH-1:0] window
`ifdef SLIDING_WINDOW_SUM_EN
    ,
    output logic [sum_width(WORD_WIDTH, DEPTH)-1:0] win_sum
`endif
);

    logic [WORD_WIDTH-1:0] r_slot [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '{default: '0};
        end else if (clear) begin
            r_slot <= '{default: '0};
        end else if (shift) begin
            r_slot[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_slot[i] <= r_slot[i-1];
            end
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_flat
        assign window[s*WORD_WIDTH +: WORD_WIDTH] = r_slot[s];
    end

`ifdef SLIDING_WINDOW_SUM_EN
    localparam int c_sum_w = sum_width(WORD_WIDTH, DEPTH);

    logic [c_sum_w-1:0] r_sum;

    // Incoming word enters, oldest word leaves: sum tracks the window exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (clear) begin
            r_sum <= '0;
        end else if (shift) begin
            r_sum <= r_sum + c_sum_w'(din) - c_sum_w'(r_slot[DEPTH-1]);
        end
    end

    assign win_sum = r_sum;
`endif

endmodule
`default_nettype wire

// File: rtl/sliding_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sliding_window_buffer
// Description : Multi-channel sliding-window buffer with valid/ready handshakes
//               and a window strobe every STRIDE samples. Optional per-channel
//               window sum enabled by defining SLIDING_WINDOW_SUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sliding_window_buffer
    import sliding_window_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int WORD_WIDTH = 4,
    parameter int DEPTH      = 21,
    parameter int STRIDE     = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [CHANNELS*WORD_WIDTH-1:0]       din,
    output logic                                 win_valid,
    input  logic                                 win_ready,
    output logic [CHANNELS*DEPTH*WORD_WIDTH-1:0] data_out_flat
`ifdef SLIDING_WINDOW_SUM_EN
    ,
    output logic [CHANNELS*sum_width(WORD_WIDTH, DEPTH)-1:0] win_sum_flat
`endif
);

    localparam int                 c_cnt_w     = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth_m1  = c_cnt_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_stride_m1 = c_cnt_w'(STRIDE - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_fill_cnt;
    logic [c_cnt_w-1:0] w_fill_next;
    logic [c_cnt_w-1:0] r_stride_cnt;
    logic [c_cnt_w-1:0] w_stride_next;
    logic               w_accept;
    logic               w_shift;

    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (v == c_depth) ? v : v + 1'b1;
    endfunction

    assign win_valid = (r_state == HOLD);
    assign in_ready  = !rst && (!win_valid || win_ready);
    assign w_accept  = in_valid && in_ready;
    // A sample offered during clear is dropped rather than shifted in.
    assign w_shift   = w_accept && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            r_fill_cnt   <= '0;
            r_stride_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_fill_cnt   <= w_fill_next;
            r_stride_cnt <= w_stride_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_fill_next   = r_fill_cnt;
        w_stride_next = r_stride_cnt;
        if (clear) begin
            w_state_next  = FILL;
            w_fill_next   = '0;
            w_stride_next = '0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_accept) begin
                        w_fill_next = sat_inc(r_fill_cnt);
                        if (r_fill_cnt == c_depth_m1) begin
                            w_state_next = HOLD;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (r_stride_cnt == c_stride_m1) begin
                            w_state_next  = HOLD;
                            w_stride_next = '0;
                        end else begin
                            w_stride_next = sat_inc(r_stride_cnt);
                        end
                    end
                end
                HOLD: begin
                    // A sample taken alongside the window is the first of the next stride.
                    if (win_ready) begin
                        if (w_accept && (STRIDE == 1)) begin
                            w_state_next  = HOLD;
                            w_stride_next = '0;
                        end else if (w_accept) begin
                            w_state_next  = RUN;
                            w_stride_next = c_cnt_w'(1);
                        end else begin
                            w_state_next  = RUN;
                            w_stride_next = '0;
                        end
                    end
                end
                default: begin
                    w_state_next  = FILL;
                    w_fill_next   = '0;
                    w_stride_next = '0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        sw_channel_lane #(
            .WORD_WIDTH (WORD_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .shift   (w_shift),
            .din     (din[(c+1)*WORD_WIDTH-1 -: WORD_WIDTH]),
            .window  (data_out_flat[c*DEPTH*WORD_WIDTH +: DEPTH*WORD_WIDTH])
`ifdef SLIDING_WINDOW_SUM_EN
            ,
            .win_sum (win_sum_flat[c*sum_width(WORD_WIDTH, DEPTH) +: sum_width(WORD_WIDTH, DEPTH)])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sliding_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sliding_window_buffer
// Description : Self-checking bench for sliding_window_buffer (STRIDE=2 and
//               STRIDE=1 instances); SLIDING_WINDOW_SUM_EN also checks sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sliding_window_buffer;

    localparam int CH = 2;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int SW = W + $clog2(D);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              a_clear = 1'b0, a_in_valid = 1'b0, a_win_ready = 1'b0;
    logic [CH*W-1:0]   a_din   = '0;
    logic              a_in_ready, a_win_valid;
    logic [CH*D*W-1:0] a_flat;
    logic              b_clear = 1'b0, b_in_valid = 1'b0, b_win_ready = 1'b0;
    logic [CH*W-1:0]   b_din   = '0;
    logic              b_in_ready, b_win_valid;
    logic [CH*D*W-1:0] b_flat;
`ifdef SLIDING_WINDOW_SUM_EN
    logic [CH*SW-1:0]  a_sum, b_sum;
`endif

    sliding_window_buffer #(.CHANNELS(CH), .WORD_WIDTH(W), .DEPTH(D), .STRIDE(2)) dut_s2 (
        .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .din(a_din), .win_valid(a_win_valid), .win_ready(a_win_ready), .data_out_flat(a_flat)
`ifdef SLIDING_WINDOW_SUM_EN
        , .win_sum_flat(a_sum)
`endif
    );

    sliding_window_buffer #(.CHANNELS(CH), .WORD_WIDTH(W), .DEPTH(D), .STRIDE(1)) dut_s1 (
        .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .din(b_din), .win_valid(b_win_valid), .win_ready(b_win_ready), .data_out_flat(b_flat)
`ifdef SLIDING_WINDOW_SUM_EN
        , .win_sum_flat(b_sum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: sample history per channel plus total accepted count.
    logic [W-1:0] m_hist [2][CH][D];
    bit           m_valid [2];
    int           m_total [2];
    int           m_stride [2] = '{2, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++)
                for (int s = 0; s < D; s++) m_hist[k][c][s] = '0;
            m_valid[k] = 1'b0;
            m_total[k] = 0;
        end
    endtask

    function automatic logic [CH*D*W-1:0] exp_flat(input int k);
        logic [CH*D*W-1:0] f = '0;
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < D; s++) f[(c*D+s)*W +: W] = m_hist[k][c][s];
        return f;
    endfunction

    function automatic int exp_sum(input int k, input int c);
        int t = 0;
        for (int s = 0; s < D; s++) t += int'(m_hist[k][c][s]);
        return t;
    endfunction

    task automatic set_in(input int k, input bit v, input logic [CH*W-1:0] d,
                          input bit wr, input bit clr);
        if (k == 0) begin
            a_in_valid = v; a_din = d; a_win_ready = wr; a_clear = clr;
        end else begin
            b_in_valid = v; b_din = d; b_win_ready = wr; b_clear = clr;
        end
    endtask

    task automatic idle();
        set_in(0, 1'b0, '0, 1'b0, 1'b0);
        set_in(1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Advance one clock and apply the window rules to both models.
    task automatic tick();
        bit              acc [2];
        bit              cons [2];
        bit              clr [2];
        logic [CH*W-1:0] d [2];
        bit              v, wr;
        for (int k = 0; k < 2; k++) begin
            v      = (k == 0) ? a_in_valid  : b_in_valid;
            wr     = (k == 0) ? a_win_ready : b_win_ready;
            clr[k] = (k == 0) ? a_clear     : b_clear;
            d[k]   = (k == 0) ? a_din       : b_din;
            acc[k]  = v && (!m_valid[k] || wr);
            cons[k] = m_valid[k] && wr;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (clr[k]) begin
                for (int c = 0; c < CH; c++)
                    for (int s = 0; s < D; s++) m_hist[k][c][s] = '0;
                m_total[k] = 0;
                m_valid[k] = 1'b0;
            end else begin
                if (acc[k]) begin
                    for (int c = 0; c < CH; c++) begin
                        for (int s = D - 1; s > 0; s--) m_hist[k][c][s] = m_hist[k][c][s-1];
                        m_hist[k][c][0] = d[k][c*W +: W];
                    end
                    m_total[k]++;
                end
                if (!(m_valid[k] && !cons[k]))
                    m_valid[k] = acc[k] && (m_total[k] >= D) &&
                                 ((m_total[k] - D) % m_stride[k] == 0);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (a_win_valid !== 1'b0 || a_flat !== '0) begin
            n_errors++;
            $display("FAIL reset_state: win_valid=%b flat=%h required 0/0", a_win_valid, a_flat);
        end
        n_checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready: a=%b b=%b required 1", a_in_ready, b_in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1'b1, CH*W'($urandom), 1'b0, 1'b0);
            tick();
        end
        idle();
        n_checks++;
        if (a_win_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_window: win_valid=%b required 1", a_win_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_win_valid !== 1'b0 || a_flat !== '0 || a_in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: win_valid=%b flat=%h in_ready=%b required 0/0/0",
                     a_win_valid, a_flat, a_in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", a_in_ready);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            set_in(0, 1'b1, {4'd15, 4'(i)}, 1'b1, 1'b0);
            tick();
            n_checks++;
            if (a_win_valid !== (i == 4) || a_win_valid !== m_valid[0]) begin
                n_errors++;
                $display("FAIL fill_valid[%0d]: win_valid=%b required %b", i, a_win_valid, i == 4);
            end
        end
        n_checks++;
        if (a_flat[15:0] !== 16'h1234 || a_flat[31:16] !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL fill_window: flat=%h required ffff1234", a_flat);
        end
        set_in(0, 1'b0, '0, 1'b1, 1'b0);
        tick();
        set_in(0, 1'b1, {4'd15, 4'd5}, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (a_win_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stride_no_window: win_valid=%b required 0", a_win_valid);
        end
        set_in(0, 1'b1, {4'd15, 4'd6}, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if (a_win_valid !== 1'b1 || a_flat[15:0] !== 16'h3456 || a_flat !== exp_flat(0)) begin
            n_errors++;
            $display("FAIL stride_window: win_valid=%b flat=%h required 1 / %h",
                     a_win_valid, a_flat, exp_flat(0));
        end
`ifdef SLIDING_WINDOW_SUM_EN
        n_checks++;
        if (a_sum[SW-1:0] !== SW'(18) || a_sum[2*SW-1:SW] !== SW'(60)) begin
            n_errors++;
            $display("FAIL window_sum: ch0=%0d ch1=%0d required 18/60",
                     a_sum[SW-1:0], a_sum[2*SW-1:SW]);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [CH*D*W-1:0] held;
        logic [CH*W-1:0]   d;
        held = a_flat;
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1'b1, CH*W'($urandom), 1'b0, 1'b0);
            #1;
            n_checks++;
            if (a_in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_in_ready[%0d]: in_ready=%b required 0", i, a_in_ready);
            end
            tick();
            n_checks++;
            if (a_flat !== held || a_win_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: flat=%h valid=%b required %h/1",
                         i, a_flat, a_win_valid, held);
            end
        end
        d = CH*W'($urandom);
        set_in(0, 1'b1, d, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release_ready: in_ready=%b required 1", a_in_ready);
        end
        tick();
        idle();
        n_checks++;
        if (a_flat[W-1:0] !== d[W-1:0] || a_flat !== exp_flat(0) || a_win_valid !== m_valid[0]) begin
            n_errors++;
            $display("FAIL bp_resume: flat=%h valid=%b required %h/%b",
                     a_flat, a_win_valid, exp_flat(0), m_valid[0]);
        end
    endtask

    task automatic test_clear();
        set_in(0, 1'b0, '0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1'b1, CH*W'($urandom_range(1, 255)), 1'b1, 1'b0);
            tick();
        end
        set_in(0, 1'b1, 8'hA5, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (a_flat !== '0 || a_win_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_flush: flat=%h valid=%b required 0/0", a_flat, a_win_valid);
        end
`ifdef SLIDING_WINDOW_SUM_EN
        n_checks++;
        if (a_sum !== '0) begin
            n_errors++;
            $display("FAIL clear_sum: sum=%h required 0", a_sum);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1'b1, CH*W'($urandom), 1'b1, 1'b0);
            tick();
            n_checks++;
            if (a_win_valid !== (i == 3)) begin
                n_errors++;
                $display("FAIL clear_refill[%0d]: win_valid=%b required %b", i, a_win_valid, i == 3);
            end
        end
        idle();
        n_checks++;
        if (a_flat !== exp_flat(0)) begin
            n_errors++;
            $display("FAIL clear_window: flat=%h required %h", a_flat, exp_flat(0));
        end
    endtask

    task automatic test_stride1();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 1'b1, {4'(i), 4'(i)}, 1'b1, 1'b0);
            tick();
            n_checks++;
            if (b_win_valid !== (i >= 3) || b_flat[W-1:0] !== 4'(i)) begin
                n_errors++;
                $display("FAIL stride1[%0d]: valid=%b slot0=%0d required %b/%0d",
                         i, b_win_valid, b_flat[W-1:0], i >= 3, i);
            end
        end
        idle();
        n_checks++;
        if (b_flat !== exp_flat(1)) begin
            n_errors++;
            $display("FAIL stride1_window: flat=%h required %h", b_flat, exp_flat(1));
        end
    endtask

    task automatic test_random();
        bit wr [2];
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                wr[k] = ($urandom % 3) != 0;
                set_in(k, ($urandom % 4) != 0, CH*W'($urandom), wr[k], ($urandom % 40) == 0);
            end
            #1;
            n_checks++;
            if (a_in_ready !== (!m_valid[0] || wr[0]) || b_in_ready !== (!m_valid[1] || wr[1])) begin
                n_errors++;
                $display("FAIL rand_ready[%0d]: a=%b b=%b required %b/%b", n, a_in_ready, b_in_ready,
                         !m_valid[0] || wr[0], !m_valid[1] || wr[1]);
            end
            tick();
            n_checks++;
            if (a_win_valid !== m_valid[0] || a_flat !== exp_flat(0) ||
                b_win_valid !== m_valid[1] || b_flat !== exp_flat(1)) begin
                n_errors++;
                $display("FAIL rand_window[%0d]: a=%b/%h b=%b/%h required %b/%h %b/%h", n,
                         a_win_valid, a_flat, b_win_valid, b_flat,
                         m_valid[0], exp_flat(0), m_valid[1], exp_flat(1));
            end
`ifdef SLIDING_WINDOW_SUM_EN
            for (int c = 0; c < CH; c++) begin
                n_checks++;
                if (int'(a_sum[c*SW +: SW]) !== exp_sum(0, c) ||
                    int'(b_sum[c*SW +: SW]) !== exp_sum(1, c)) begin
                    n_errors++;
                    $display("FAIL rand_sum[%0d] ch%0d: a=%0d b=%0d required %0d/%0d", n, c,
                             a_sum[c*SW +: SW], b_sum[c*SW +: SW], exp_sum(0, c), exp_sum(1, c));
                end
            end
`endif
        end
        idle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_fill();
        test_backpressure();
        test_clear();
        test_stride1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
